// File: rtl/ifu.sv
// Instruction fetch unit: PC register, 2-entry fetch buffer toward decode, redirect and ebreak halt handling.
// Define IFU_TRACE_EN to print a line per fetched word and a message on halt (simulation only).
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  if (DEPTH != 2) begin : g_bad_depth
    $error("ifu: only DEPTH=2 is supported");
  end

  state_t      state, state_next;
  logic [31:0] pc;
  logic [1:0]  count, count_next;
  logic [1:0]  occ_after_pop;
  logic        pop, flush, is_ebreak;
  logic        unused_bits;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];

  assign out_valid     = (count != 2'd0) && (state != HALTED);
  assign pop           = out_valid && out_ready;
  assign occ_after_pop = count - {1'b0, pop};
  assign flush         = redirect_valid && (state != HALTED);
  assign is_ebreak     = (imem_rdata == EBREAK);
  assign imem_addr     = pc;
  assign out_pc        = buf_pc[0];
  assign out_instr     = buf_instr[0];
  assign halted        = (state == HALTED);
  assign unused_bits   = &{1'b0, redirect_pc[1:0]};

  // Fetch is gated by rst_n so no request escapes while reset is held.
  always_comb begin
    state_next = state;
    imem_en    = 1'b0;
    count_next = occ_after_pop;
    case (state)
      RUN: begin
        imem_en    = rst_n && (occ_after_pop < 2'd2) && !redirect_valid;
        count_next = occ_after_pop + {1'b0, imem_en};
        if (flush)
          count_next = 2'd0;
        else if (imem_en && is_ebreak)
          state_next = HALT_PEND;
      end
      HALT_PEND: begin
        if (flush) begin
          count_next = 2'd0;
          state_next = RUN;
        end else if (pop && occ_after_pop == 2'd0) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        count_next = 2'd0;
      end
      default: begin
        state_next = RUN;
        count_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
      count <= 2'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (flush)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (imem_en)
        pc <= pc + 32'd4;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down before the push lands.
  always_ff @(posedge clk) begin
    if (pop) begin
      buf_pc[0]    <= buf_pc[1];
      buf_instr[0] <= buf_instr[1];
    end
    if (imem_en) begin
      buf_pc[occ_after_pop[0]]    <= pc;
      buf_instr[occ_after_pop[0]] <= imem_rdata;
    end
  end

`ifdef IFU_TRACE_EN
  always @(posedge clk) begin
    if (imem_en)
      $display("PC: %h instr: %b", pc, imem_rdata);
    if (rst_n && state != HALTED && state_next == HALTED)
      $display("IFU halted");
  end
`endif

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the fetch-buffer entry count; only the value 2 is legal.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_en  output  1  fetch request this cycle.
REQ-006 SHALL have port imem_addr  output  32  fetch address, always equal to the PC register.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid combinationally in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request from the execute stage.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port out_valid  output  1  buffer head valid toward decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts the head.
REQ-012 SHALL have port out_pc  output  32  PC of the head entry.
REQ-013 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-014 SHALL have port halted  output  1  ebreak has retired from fetch and the core is stopped.

Function
REQ-015 SHALL implement states RUN, HALT_PEND and HALTED.
REQ-016 In RUN, imem_en SHALL be 1 when, after this cycle's pop, buffer occupancy is below 2 and redirect_valid is 0.
- On each fetch, {pc, imem_rdata} is pushed at the tail.
- pc <= pc + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-017 The buffer SHALL be a FIFO: the head is popped when out_valid && out_ready.
- A push and a pop in the same cycle SHALL leave occupancy unchanged.
- out_valid = (occupancy != 0).
- The head SHALL be stable while out_valid && !out_ready.
REQ-018 Fetch-to-output latency SHALL be one cycle: a word fetched in cycle N is presented at the head in cycle N+1 if the buffer was empty.
REQ-019 Sustained throughput SHALL be one instruction per cycle with out_ready held high.
REQ-020 On redirect_valid=1, the block SHALL:
- flush all entries, including any entry popped in the same cycle, which counts as consumed;
- suppress the fetch in that cycle;
- set pc <= {redirect_pc[31:2], 2'b00};
- deassert out_valid on the next cycle and fetch from the target on the next cycle.
REQ-021 When a fetched word equals 32'h0010_0073 (ebreak), the block SHALL push it and go to HALT_PEND, with no further fetches.
REQ-022 In HALT_PEND:
- a redirect SHALL flush the buffer and return to RUN (the ebreak was squashed);
- otherwise, when the buffer becomes empty by popping, the block SHALL go to HALTED.
REQ-023 In HALTED: halted=1, imem_en=0, out_valid=0, and redirect_valid SHALL be ignored; only reset exits.
REQ-024 In a fetch cycle where redirect_valid=1 and the word is an ebreak, the redirect SHALL win and no ebreak is recorded.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately, asynchronously and at any time (including mid-halt or mid-stall), force:
- pc=RESET_PC;
- occupancy=0;
- state=RUN;
- out_valid=0, halted=0, imem_en=0.
REQ-026 The first fetch (imem_en=1, imem_addr=RESET_PC) SHALL occur in the first clk cycle after rst_n rises.
REQ-027 Buffer data registers need no reset; out_pc and out_instr are don't-care while out_valid=0.

Configuration
REQ-028 With macro IFU_TRACE_EN defined, each push SHALL print one simulation line of the form "PC: <pc hex> instr: <instr binary>", and entry to HALTED SHALL print "IFU halted".
REQ-029 Without IFU_TRACE_EN, the block SHALL print nothing, and its behaviour and ports SHALL be identical to the traced build.

Verification
REQ-030 Reset, out_ready=1, memory returns addi words -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles starting cycle 2; out_valid continuous.
REQ-031 out_ready=0 for 5 cycles from cycle 1 -> exactly 2 entries fetched (0x80000000, 0x80000004), imem_en=0 thereafter, head stays 0x80000000; on release, no skipped or duplicated PCs.
REQ-032 Redirect to 0x80000102 while 2 entries are buffered -> next cycle out_valid=0 and imem_addr=0x80000100; following cycle out_pc=0x80000100.
REQ-033 Word at 0x8000000C = 32'h00100073 -> no imem_en after that fetch; halted=1 the cycle after the ebreak is popped; a later redirect is ignored.
REQ-034 Ebreak buffered, then redirect to 0x80000200 -> state returns to RUN, halted stays 0, fetch resumes at 0x80000200.
REQ-035 rst_n pulsed low mid-operation with halted=1 -> outputs clear asynchronously; after release, fetch restarts at 0x80000000.
